// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between the IFU and the LSU, one transaction
//            in flight. Define ARB_ROUND_ROBIN_EN for an alternating tie-break.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch side
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  // load/store side
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  // memory side
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);

  localparam int   c_MASK_W  = DATA_W / 8;
  localparam logic c_OWN_IFU = 1'b0;
  localparam logic c_OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_wen;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_MASK_W-1:0]   r_wmask;

  logic                  w_idle;
  logic                  w_grant_lsu;
  logic                  w_accept;
  logic                  w_resp_fire;

  assign w_idle = (r_state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On a tie, the requester that did not win last time takes the port.
  always_comb begin
    w_grant_lsu = lsu_req_valid && (!ifu_req_valid || (r_last_grant == c_OWN_IFU));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= c_OWN_IFU;
    end else if (w_accept) begin
      r_last_grant <= w_grant_lsu ? c_OWN_LSU : c_OWN_IFU;
    end
  end
`else
  always_comb begin
    w_grant_lsu = lsu_req_valid;
  end
`endif

  always_comb begin
    ifu_req_ready = w_idle && !rst && ifu_req_valid && !w_grant_lsu;
    lsu_req_ready = w_idle && !rst && w_grant_lsu;
    w_accept      = ifu_req_ready || lsu_req_ready;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)       w_state_nxt = S_REQ;
      S_REQ:   if (mem_req_ready)  w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_resp_valid) w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= c_OWN_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      if (w_grant_lsu) begin
        r_owner <= c_OWN_LSU;
        r_addr  <= lsu_req_addr;
        r_wen   <= lsu_req_wen;
        r_wdata <= lsu_req_wdata;
        // Loads never carry byte enables to memory.
        r_wmask <= lsu_req_wen ? lsu_req_wmask : '0;
      end else begin
        r_owner <= c_OWN_IFU;
        r_addr  <= ifu_req_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port and response routing
  // ---------------------------------------------------------------------------
  assign busy          = !w_idle;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

  // Responses outside WAIT are stray and dropped; a reset cycle drops them too.
  assign w_resp_fire = (r_state == S_WAIT) && mem_resp_valid && !rst;

  always_comb begin
    ifu_resp_valid = w_resp_fire && (r_owner == c_OWN_IFU);
    lsu_resp_valid = w_resp_fire && (r_owner == c_OWN_LSU);
    ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
    lsu_resp_data  = lsu_resp_valid ? mem_resp_data : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Transaction-level bench for mem_port_arbiter (directed + random).
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr = '0;
  logic        ifu_resp_valid;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr = '0;
  logic        lsu_req_wen = 1'b0;
  logic [63:0] lsu_req_wdata = '0;
  logic [7:0]  lsu_req_wmask = '0;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit m_last_lsu = 1'b0;  // model: 1 when the LSU won the previous accept

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule: a lone requester always wins; ties go to LSU, or to the
  // side that did not win last time when the tie-break alternates.
  function automatic bit pick_lsu(input bit iv, input bit lv);
    if (!lv) return 1'b0;
    if (!iv) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !m_last_lsu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic scramble_reqs();
    ifu_req_valid = 1'($urandom);
    lsu_req_valid = 1'($urandom);
    ifu_req_addr  = {$urandom, $urandom};
    lsu_req_addr  = {$urandom, $urandom};
    lsu_req_wen   = 1'($urandom);
    lsu_req_wdata = {$urandom, $urandom};
    lsu_req_wmask = 8'($urandom);
  endtask

  // One full transaction. Entered shortly after a falling edge with the DUT idle.
  task automatic do_txn(input bit iv, input bit lv,
                        input logic [63:0] ia, input logic [63:0] la,
                        input bit wen, input logic [63:0] wd, input logic [7:0] wm,
                        input int stall, input int dly,
                        input bit spur_idle, input bit spur_req,
                        input logic [63:0] rdata, input bit abort);
    bit          win_lsu;
    logic [63:0] e_addr, e_wdata;
    logic        e_wen;
    logic [7:0]  e_wmask;

    if (spur_idle) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      #1;
      check_val("idle_spur_ifu_resp", ifu_resp_valid, 0);
      check_val("idle_spur_lsu_resp", lsu_resp_valid, 0);
      @(posedge clk);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      #1;
      check_val("idle_spur_busy", busy, 0);
    end

    ifu_req_valid = iv;  ifu_req_addr  = ia;
    lsu_req_valid = lv;  lsu_req_addr  = la;
    lsu_req_wen   = wen; lsu_req_wdata = wd; lsu_req_wmask = wm;
    #1;
    win_lsu = pick_lsu(iv, lv);
    check_val("ifu_ready", ifu_req_ready, !win_lsu);
    check_val("lsu_ready", lsu_req_ready, win_lsu);
    check_val("idle_busy", busy, 0);
    check_val("idle_mem_valid", mem_req_valid, 0);

    if (win_lsu) begin
      e_addr = la; e_wen = wen; e_wdata = wd; e_wmask = wen ? wm : 8'h00;
    end else begin
      e_addr = ia; e_wen = 1'b0; e_wdata = '0; e_wmask = 8'h00;
    end
    @(posedge clk);
    m_last_lsu = win_lsu;
    @(negedge clk);

    for (int c = 0; c <= stall; c++) begin
      scramble_reqs();
      mem_req_ready  = (c == stall);
      mem_resp_valid = spur_req && (c == 0);
      mem_resp_data  = rdata;
      #1;
      check_val("req_busy", busy, 1);
      check_val("req_mem_valid", mem_req_valid, 1);
      check_val("req_addr", mem_req_addr, e_addr);
      check_val("req_wen", mem_req_wen, e_wen);
      check_val("req_wdata", mem_req_wdata, e_wdata);
      check_val("req_wmask", mem_req_wmask, e_wmask);
      check_val("req_readies", {ifu_req_ready, lsu_req_ready}, 0);
      check_val("req_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
      @(posedge clk);
      @(negedge clk);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;

    if (abort) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_last_lsu = 1'b0;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_mem_valid", mem_req_valid, 0);
      check_val("abort_addr_cleared", mem_req_addr, 0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      #1;
      check_val("abort_late_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
      @(posedge clk);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      return;
    end

    for (int d = 0; d < dly; d++) begin
      scramble_reqs();
      #1;
      check_val("wait_busy", busy, 1);
      check_val("wait_mem_valid", mem_req_valid, 0);
      check_val("wait_readies", {ifu_req_ready, lsu_req_ready}, 0);
      check_val("wait_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
      @(posedge clk);
      @(negedge clk);
    end

    scramble_reqs();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    #1;
    check_val("resp_ifu_valid", ifu_resp_valid, !win_lsu);
    check_val("resp_lsu_valid", lsu_resp_valid, win_lsu);
    check_val("resp_data", win_lsu ? lsu_resp_data : ifu_resp_data, rdata);
    check_val("resp_mem_valid", mem_req_valid, 0);
    @(posedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    #1;
    check_val("post_busy", busy, 0);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_mem_valid", mem_req_valid, 0);
    check_val("rst_addr", mem_req_addr, 0);
    check_val("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    check_val("rst_readies", {ifu_req_ready, lsu_req_ready}, 0);
    rst = 1'b0;
    @(negedge clk);

    // IFU fetch, answer two cycles after the handshake
    do_txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h00, 0, 1, 0, 0,
           64'h0010_0073, 0);
    // LSU store with three stalled REQ cycles
    do_txn(0, 1, 64'h0, 64'h8000_1000, 1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 3, 0, 0, 0,
           64'h0, 0);
    // LSU load: mask must not reach memory
    do_txn(0, 1, 64'h0, 64'h8000_1008, 0, 64'h1234, 8'hA5, 1, 2, 0, 0,
           64'h5555_AAAA_0000_FFFF, 0);

    // Contention: reset the tie-break history first
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last_lsu = 1'b0;
    do_txn(1, 1, 64'h8000_0000, 64'h8000_2000, 0, 64'h0, 8'h00, 0, 0, 0, 0, 64'h11, 0);
    do_txn(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h00, 0, 0, 0, 0, 64'h22, 0);
    for (int k = 0; k < 4; k++)
      do_txn(1, 1, 64'h8000_0000, 64'h8000_2000, 0, 64'h0, 8'h00, 0, 0, 0, 0,
             64'(k + 100), 0);

    // Stray responses in IDLE and REQ
    do_txn(1, 0, 64'h8000_0040, 64'h0, 0, 64'h0, 8'h00, 2, 1, 1, 1, 64'hFEED, 0);

    // Reset during WAIT with LSU owner, then an immediate IFU fetch
    do_txn(0, 1, 64'h0, 64'h8000_3000, 0, 64'h0, 8'h00, 0, 1, 0, 0, 64'hBAD, 1);
    do_txn(1, 0, 64'h8000_0100, 64'h0, 0, 64'h0, 8'h00, 0, 0, 0, 0, 64'h77, 0);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
             {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Grants one requester at a time, latches its request, drives the memory port and routes the response back to the owner.
- Sits between the IFU/LSU and the memory-side bus; it sequences the ld/sd traffic produced by the decoded mem_wen/is_load/wmask signals.
- Exactly one transaction is outstanding at a time.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; mask width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  fetch data valid (one cycle)
ifu_resp_data  out  DATA_W  fetch data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  ADDR_W  load/store address
lsu_req_wen  in  1  1=store, 0=load
lsu_req_wdata  in  DATA_W  store data
lsu_req_wmask  in  DATA_W/8  store byte mask
lsu_resp_valid  out  1  load data or store ack (one cycle)
lsu_resp_data  out  DATA_W  load data; don't-care for stores
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  latched address
mem_req_wen  out  1  latched write enable
mem_req_wdata  out  DATA_W  latched write data
mem_req_wmask  out  DATA_W/8  latched mask
mem_resp_valid  in  1  memory response
mem_resp_data  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- The single clock is clk. Reset rst is synchronous and active-high.
- The FSM has three states: IDLE, REQ and WAIT. Reset state is IDLE.
- Reset values: all outputs 0, owner=IFU, latched address/data/mask = 0.
- IDLE:
  - Grant is combinational. The default fixed priority is LSU over IFU.
  - Only the granted requester sees ready=1, and only if its valid=1; the other requester sees ready=0.
  - On valid&ready: latch addr, wen, wdata and wmask, record owner, go to REQ.
  - IFU requests latch wen=0, wmask=0 and wdata=0.
  - LSU loads (wen=0) force the latched wmask to 0.
- REQ:
  - mem_req_valid=1, and mem_req_* come from the latches, stable until the handshake.
  - On mem_req_ready, go to WAIT. Otherwise hold REQ indefinitely.
- WAIT:
  - mem_req_valid=0.
  - When mem_resp_valid=1, the owner's resp_valid=1 in the same cycle (combinational pass-through), with resp_data=mem_resp_data. Then go to IDLE.
  - The non-owner's resp_valid stays 0.
- Stores also complete only on mem_resp_valid, which serves as the write ack.
- Latency:
  - Accept at cycle N gives mem_req_valid at N+1.
  - The response is forwarded in the cycle it arrives.
  - The next accept is possible in the first cycle after WAIT exits, so the minimum is 3 cycles per transaction.
- mem_resp_valid in IDLE or REQ is ignored, with no resp_valid to either requester.
- Both requesters valid in IDLE: the winner is granted and the loser's ready=0; the loser must hold valid.
- Requesters are not required to hold valid after the handshake. Request inputs are don't-care outside IDLE.
- During REQ and WAIT, both ready outputs are 0.
- busy=1 in REQ and WAIT.
- rst asserted in any state: IDLE on the next edge; the in-flight transaction is dropped with no resp_valid emitted; latches are cleared.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Tie-break alternates. A 1-bit last_grant register (reset = IFU) updates on each accept.
  - On simultaneous valid, the requester not granted last wins.
  - A lone requester is always granted.
- Undefined: fixed LSU-over-IFU priority, and no last_grant register exists.

Test Plan:
- IFU read, addr=0x80000000, mem_req_ready held 1, memory answers 0x00100073 two cycles after the handshake:
  - ifu_req_ready=1 at accept.
  - mem_req_valid with addr 0x80000000, wen=0, wmask=0 on the next cycle.
  - ifu_resp_valid=1 with data 0x00100073 exactly in the mem_resp_valid cycle.
  - lsu_resp_valid stays 0.
- LSU store, addr=0x80001000, wdata=0xDEADBEEFCAFEF00D, wmask=0xFF, mem_req_ready low for 3 cycles:
  - mem_req_* held stable for all 4 REQ cycles.
  - lsu_resp_valid=1 on the ack.
- Both valid in IDLE (addrs 0x80000000 IFU / 0x80002000 LSU), macro off:
  - LSU granted first and IFU second.
  - Four consecutive both-valid rounds give LSU every time (IFU starves while LSU holds valid).
- Same as above with ARB_ROUND_ROBIN_EN: grants alternate LSU, IFU, LSU, IFU. This holds because last_grant resets to IFU.
- Spurious mem_resp_valid=1 in IDLE and in REQ: no resp_valid on either side and no state change.
- rst asserted during WAIT with LSU owner:
  - busy=0 and mem_req_valid=0 the next cycle.
  - A later mem_resp_valid produces no lsu_resp_valid.
  - A fresh IFU request is accepted immediately after reset deasserts.
